mem_arbiter: RTL and testbench

//  Shares the single word-level memory port (byte-serial memory engine) between instruction fetch and the

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (fetch, load/store buffer)
// and the byte-serial memory engine.
interface mem_arbiter_if;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic [31:0] if_data;

  logic        ls_en;
  logic [31:0] ls_addr;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_rdy;
  logic [31:0] ls_rdata;

  logic        m_en;
  logic [31:0] m_addr;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic        m_rdy;
  logic [31:0] m_rdata;

  // Arbiter view: takes requests, drives responses and the engine request.
  modport slave (
    input  if_en, if_addr, ls_en, ls_addr, ls_wr, ls_size, ls_wdata, m_rdy, m_rdata,
    output if_rdy, if_data, ls_rdy, ls_rdata, m_en, m_addr, m_wr, m_size, m_wdata
  );

  // Requester/engine view.
  modport master (
    output if_en, if_addr, ls_en, ls_addr, ls_wr, ls_size, ls_wdata, m_rdy, m_rdata,
    input  if_rdy, if_data, ls_rdy, ls_rdata, m_en, m_addr, m_wr, m_size, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single memory-engine port between instruction fetch and the load/store buffer,
// with LSB priority, a fetch starvation cap, flush discard and IO-store back-pressure.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = 32'h30000
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  input logic          flush,
  input logic          io_buffer_full,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_BUSY = 3'd1,
    LS_BUSY = 3'd2,
    IO_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             discard_q, discard_d;
  logic             cur_if_q, cur_if_d;
  req_t             req_q, req_d;
  logic             m_en_q, m_en_d;
  logic [31:0]      resp_q, resp_d;
  logic             if_rdy_q, if_rdy_d;
  logic             ls_rdy_q, ls_rdy_d;
  logic [31:0]      if_data_q, if_data_d;
  logic [31:0]      ls_rdata_q, ls_rdata_d;

  logic if_req, ls_req, ls_win, io_stall, pulse_busy, is_store;

  // Flush hides fetches and loads from arbitration; stores always proceed.
  assign if_req     = bus.if_en & ~flush;
  assign ls_req     = bus.ls_en & (bus.ls_wr | ~flush);
  assign ls_win     = ls_req & (~if_req | (starve_q < CNT_W'(STARVE_LIMIT)));
  assign io_stall   = bus.ls_wr & (bus.ls_addr >= IO_BASE) & io_buffer_full;
  assign pulse_busy = if_rdy_q | ls_rdy_q;
  assign is_store   = ~cur_if_q & req_q.wr;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    discard_d  = discard_q;
    cur_if_d   = cur_if_q;
    req_d      = req_q;
    m_en_d     = m_en_q;
    resp_d     = resp_q;
    if_rdy_d   = 1'b0;
    ls_rdy_d   = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      IDLE: begin
        // The requester still holds en during its rdy cycle, so no grant then.
        if (!pulse_busy) begin
          if (ls_win) begin
            cur_if_d = 1'b0;
            req_d    = '{addr: bus.ls_addr, wr: bus.ls_wr, size: bus.ls_size, wdata: bus.ls_wdata};
            if (if_req && starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
            if (io_stall) begin
              state_d = IO_WAIT;
            end else begin
              state_d = LS_BUSY;
              m_en_d  = 1'b1;
            end
          end else if (if_req) begin
            cur_if_d = 1'b1;
            req_d    = '{addr: bus.if_addr, wr: 1'b0, size: 2'd2, wdata: 32'd0};
            starve_d = '0;
            state_d  = IF_BUSY;
            m_en_d   = 1'b1;
          end
        end
      end
      IO_WAIT: begin
        if (!io_buffer_full) begin
          state_d = LS_BUSY;
          m_en_d  = 1'b1;
        end
      end
      IF_BUSY, LS_BUSY: begin
        // The engine cannot be aborted; a flushed transfer finishes and is dropped.
        if (flush && !is_store) discard_d = 1'b1;
        if (bus.m_rdy) begin
          m_en_d = 1'b0;
          resp_d = bus.m_rdata;
          if ((discard_q || flush) && !is_store) begin
            state_d   = IDLE;
            discard_d = 1'b0;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (cur_if_q) begin
          if (!flush) begin
            if_rdy_d  = 1'b1;
            if_data_d = resp_q;
          end
        end else if (req_q.wr) begin
          ls_rdy_d = 1'b1;
        end else if (!flush) begin
          ls_rdy_d   = 1'b1;
          ls_rdata_d = resp_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      discard_q  <= 1'b0;
      cur_if_q   <= 1'b0;
      req_q      <= '0;
      m_en_q     <= 1'b0;
      resp_q     <= '0;
      if_rdy_q   <= 1'b0;
      ls_rdy_q   <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      discard_q  <= discard_d;
      cur_if_q   <= cur_if_d;
      req_q      <= req_d;
      m_en_q     <= m_en_d;
      resp_q     <= resp_d;
      if_rdy_q   <= if_rdy_d;
      ls_rdy_q   <= ls_rdy_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // A pulse caught by a freeze is masked and reappears once rdy_in returns.
  assign bus.if_rdy   = if_rdy_q & rdy_in;
  assign bus.ls_rdy   = ls_rdy_q & rdy_in;
  assign bus.if_data  = if_data_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.m_en     = m_en_q;
  assign bus.m_addr   = req_q.addr;
  assign bus.m_wr     = req_q.wr;
  assign bus.m_size   = req_q.size;
  assign bus.m_wdata  = req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory engine model.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic rdy_in;
  logic flush;
  logic io_full;

  int checks = 0;
  int errors = 0;

  int          eng_lat;
  logic [31:0] eng_data;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4), .IO_BASE(32'h30000)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy_in),
    .flush         (flush),
    .io_buffer_full(io_full),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine: m_rdy for one accepted cycle after m_en has been high eng_lat cycles; frozen by rdy_in.
  initial begin
    int   cnt;
    logic en_s, r_s, rs_s;
    cnt         = 0;
    bus.m_rdy   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      en_s = bus.m_en;
      r_s  = rdy_in;
      rs_s = rst;
      #1;
      if (rs_s) begin
        cnt       = 0;
        bus.m_rdy = 1'b0;
      end else if (r_s) begin
        if (bus.m_rdy) begin
          bus.m_rdy = 1'b0;
          cnt       = 0;
        end else if (en_s) begin
          cnt++;
          if (cnt == eng_lat - 1) begin
            bus.m_rdy   = 1'b1;
            bus.m_rdata = eng_data;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return bus.m_en;
      1:       return bus.if_rdy;
      default: return bus.ls_rdy;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sig_of(which) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic idle_inputs();
    bus.if_en    = 1'b0;
    bus.if_addr  = '0;
    bus.ls_en    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wr    = 1'b0;
    bus.ls_size  = '0;
    bus.ls_wdata = '0;
    flush        = 1'b0;
    io_full      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy_in = 1'b1;
    idle_inputs();
    eng_lat = 4;
    eng_data = '0;
    step();
    step();
    checks++; if (bus.m_en !== 1'b0) begin errors++; $display("FAIL reset_m_en got %b want 0", bus.m_en); end
    checks++; if (bus.m_addr !== 32'd0) begin errors++; $display("FAIL reset_m_addr got %h want 0", bus.m_addr); end
    checks++; if (bus.m_wr !== 1'b0) begin errors++; $display("FAIL reset_m_wr got %b want 0", bus.m_wr); end
    checks++; if (bus.m_size !== 2'd0) begin errors++; $display("FAIL reset_m_size got %0d want 0", bus.m_size); end
    checks++; if (bus.if_rdy !== 1'b0) begin errors++; $display("FAIL reset_if_rdy got %b want 0", bus.if_rdy); end
    checks++; if (bus.ls_rdy !== 1'b0) begin errors++; $display("FAIL reset_ls_rdy got %b want 0", bus.ls_rdy); end
    checks++; if (bus.if_data !== 32'd0) begin errors++; $display("FAIL reset_if_data got %h want 0", bus.if_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    eng_lat = 4;
    eng_data = 32'h00A00093;
    bus.if_addr = 32'h100;
    bus.if_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (bus.m_en !== 1'(c >= 1 && c <= 4)) begin errors++; $display("FAIL fetch_m_en cy%0d got %b want %b", c, bus.m_en, c >= 1 && c <= 4); end
      checks++;
      if (bus.if_rdy !== 1'(c == 6)) begin errors++; $display("FAIL fetch_if_rdy cy%0d got %b want %b", c, bus.if_rdy, c == 6); end
      if (c == 1) begin
        checks++; if (bus.m_addr !== 32'h100) begin errors++; $display("FAIL fetch_m_addr got %h want 00000100", bus.m_addr); end
        checks++; if (bus.m_size !== 2'd2 || bus.m_wr !== 1'b0) begin errors++; $display("FAIL fetch_m_size_wr got %0d/%b want 2/0", bus.m_size, bus.m_wr); end
      end
      if (c == 6) begin
        checks++; if (bus.if_data !== 32'h00A00093) begin errors++; $display("FAIL fetch_if_data got %h want 00a00093", bus.if_data); end
      end
      if (c == 7) bus.if_en = 1'b0;
    end
  endtask

  task automatic test_starvation();
    bit ok;
    eng_lat = 2;
    eng_data = 32'h0BADF00D;
    bus.if_addr = 32'h100;
    bus.if_en = 1'b1;
    bus.ls_addr = 32'h2000;
    bus.ls_wr = 1'b0;
    bus.ls_size = 2'd2;
    bus.ls_en = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_for(0, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL starve_grant%0d timeout waiting m_en", g); end
      checks++;
      if (bus.m_addr !== ((g < 4) ? 32'h2000 : 32'h100)) begin
        errors++; $display("FAIL starve_grant%0d_addr got %h want %h", g, bus.m_addr, (g < 4) ? 32'h2000 : 32'h100);
      end
      if (g < 4) begin
        wait_for(2, 20, ok);
        checks++; if (!ok || bus.ls_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL starve_ls_rdata%0d got %h want 0badf00d", g, bus.ls_rdata); end
      end else begin
        eng_data = 32'h00000013;
        wait_for(1, 20, ok);
        checks++; if (!ok || bus.if_data !== 32'h00000013) begin errors++; $display("FAIL starve_if_data got %h want 00000013", bus.if_data); end
      end
      step();
    end
    bus.if_en = 1'b0;
    bus.ls_en = 1'b0;
    step();
    step();
    checks++; if (bus.m_en !== 1'b0) begin errors++; $display("FAIL starve_quiet got %b want 0", bus.m_en); end
  endtask

  task automatic test_io_wait();
    int pulses;
    pulses = 0;
    eng_lat = 2;
    io_full = 1'b1;
    bus.ls_addr = 32'h30000;
    bus.ls_wr = 1'b1;
    bus.ls_size = 2'd2;
    bus.ls_wdata = 32'hDEADBEEF;
    bus.ls_en = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++;
      if (bus.m_en !== 1'(c == 11 || c == 12)) begin errors++; $display("FAIL io_m_en cy%0d got %b want %b", c, bus.m_en, c == 11 || c == 12); end
      if (bus.ls_rdy === 1'b1) pulses++;
      if (c == 11) begin
        checks++;
        if (bus.m_addr !== 32'h30000 || bus.m_wr !== 1'b1 || bus.m_wdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL io_req got %h/%b/%h want 00030000/1/deadbeef", bus.m_addr, bus.m_wr, bus.m_wdata);
        end
      end
      if (c == 14) begin
        checks++; if (bus.ls_rdy !== 1'b1) begin errors++; $display("FAIL io_ls_rdy cy14 got %b want 1", bus.ls_rdy); end
      end
      if (c == 10) io_full = 1'b0;
      if (c == 15) bus.ls_en = 1'b0;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL io_pulse_count got %0d want 1", pulses); end
  endtask

  task automatic test_flush_fetch();
    bit ok;
    eng_lat = 4;
    bus.if_addr = 32'h200;
    bus.if_en = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (bus.m_en !== 1'(c <= 4 || c == 6)) begin errors++; $display("FAIL flushf_m_en cy%0d got %b want %b", c, bus.m_en, c <= 4 || c == 6); end
      checks++;
      if (bus.if_rdy !== 1'b0) begin errors++; $display("FAIL flushf_if_rdy cy%0d got %b want 0", c, bus.if_rdy); end
      if (c == 2) begin
        flush = 1'b1;
        bus.if_en = 1'b0;
      end
      if (c == 3) flush = 1'b0;
      if (c == 5) begin
        checks++; if (bus.if_data !== 32'h00000013) begin errors++; $display("FAIL flushf_data_held got %h want 00000013", bus.if_data); end
        bus.if_addr = 32'h300;
        bus.if_en = 1'b1;
        eng_data = 32'h11111111;
      end
      if (c == 6) begin
        checks++; if (bus.m_addr !== 32'h300) begin errors++; $display("FAIL flushf_next_addr got %h want 00000300", bus.m_addr); end
      end
    end
    wait_for(1, 20, ok);
    checks++; if (!ok || bus.if_data !== 32'h11111111) begin errors++; $display("FAIL flushf_next_data got %h want 11111111", bus.if_data); end
    step();
    bus.if_en = 1'b0;
    step();
  endtask

  task automatic test_flush_store();
    eng_lat = 3;
    flush = 1'b1;
    bus.ls_addr = 32'h1000;
    bus.ls_wr = 1'b1;
    bus.ls_size = 2'd0;
    bus.ls_wdata = 32'h55;
    bus.ls_en = 1'b1;
    bus.if_addr = 32'h500;
    bus.if_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (bus.m_en !== 1'(c <= 3)) begin errors++; $display("FAIL flushs_m_en cy%0d got %b want %b", c, bus.m_en, c <= 3); end
      checks++;
      if (bus.ls_rdy !== 1'(c == 5)) begin errors++; $display("FAIL flushs_ls_rdy cy%0d got %b want %b", c, bus.ls_rdy, c == 5); end
      if (c == 1) begin
        checks++;
        if (bus.m_addr !== 32'h1000 || bus.m_wr !== 1'b1 || bus.m_size !== 2'd0 || bus.m_wdata !== 32'h55) begin
          errors++; $display("FAIL flushs_req got %h/%b/%0d/%h want 00001000/1/0/00000055", bus.m_addr, bus.m_wr, bus.m_size, bus.m_wdata);
        end
        bus.if_en = 1'b0;
      end
      if (c == 3) flush = 1'b0;
      if (c == 5) bus.ls_en = 1'b0;
      if (c == 6) begin
        flush = 1'b1;
        bus.ls_addr = 32'h2000;
        bus.ls_wr = 1'b0;
        bus.ls_size = 2'd2;
        bus.ls_en = 1'b1;
      end
      if (c == 7) begin
        flush = 1'b0;
        bus.ls_en = 1'b0;
      end
    end
  endtask

  task automatic test_freeze_reset();
    eng_lat = 3;
    eng_data = 32'hCAFEF00D;
    bus.if_addr = 32'h400;
    bus.if_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if (bus.m_en !== 1'(c <= 6)) begin errors++; $display("FAIL freeze_m_en cy%0d got %b want %b", c, bus.m_en, c <= 6); end
      checks++;
      if (bus.if_rdy !== 1'(c == 8)) begin errors++; $display("FAIL freeze_if_rdy cy%0d got %b want %b", c, bus.if_rdy, c == 8); end
      if (c == 8) begin
        checks++; if (bus.if_data !== 32'hCAFEF00D) begin errors++; $display("FAIL freeze_if_data got %h want cafef00d", bus.if_data); end
      end
      if (c == 3) rdy_in = 1'b0;
      if (c == 6) rdy_in = 1'b1;
      if (c == 9) bus.if_en = 1'b0;
    end
    eng_lat = 10;
    bus.ls_addr = 32'h1004;
    bus.ls_wr = 1'b1;
    bus.ls_size = 2'd1;
    bus.ls_wdata = 32'h12345678;
    bus.ls_en = 1'b1;
    step();
    checks++; if (bus.m_en !== 1'b1 || bus.m_size !== 2'd1) begin errors++; $display("FAIL rst_pre_req got %b/%0d want 1/1", bus.m_en, bus.m_size); end
    step();
    step();
    rst = 1'b1;
    bus.ls_en = 1'b0;
    step();
    checks++; if (bus.m_en !== 1'b0) begin errors++; $display("FAIL rst_m_en got %b want 0", bus.m_en); end
    checks++; if (bus.m_addr !== 32'd0 || bus.m_wdata !== 32'd0) begin errors++; $display("FAIL rst_m_addr_wdata got %h/%h want 0/0", bus.m_addr, bus.m_wdata); end
    checks++; if (bus.m_wr !== 1'b0 || bus.m_size !== 2'd0) begin errors++; $display("FAIL rst_m_wr_size got %b/%0d want 0/0", bus.m_wr, bus.m_size); end
    checks++; if (bus.if_data !== 32'd0 || bus.ls_rdata !== 32'd0) begin errors++; $display("FAIL rst_data got %h/%h want 0/0", bus.if_data, bus.ls_rdata); end
    rst = 1'b0;
    step();
    step();
    checks++; if (bus.m_en !== 1'b0 || bus.ls_rdy !== 1'b0) begin errors++; $display("FAIL rst_after got %b/%b want 0/0", bus.m_en, bus.ls_rdy); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starvation();
    test_io_wait();
    test_flush_fetch();
    test_flush_store();
    test_freeze_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
